// File: rtl/soc_event_fifo_sink.sv
// rtl/soc_event_fifo_sink.sv - grant consumer: ack, lowest-index encode, FWFT event ID FIFO
module soc_event_fifo_sink #(
    parameter int EVNT_NUM = 256,
    parameter int ID_WIDTH = $clog2(EVNT_NUM),
    parameter int DEPTH    = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [EVNT_NUM-1:0]        grant_i,
    input  logic                       any_grant_i,
    output logic                       grant_ack_o,
    output logic                       evt_valid_o,
    output logic [ID_WIDTH-1:0]        evt_data_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic [1:0]                 err_o,
    input  logic                       clr_err_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [1:0]          err_q, err_d;
    logic [ID_WIDTH-1:0] mem_q [DEPTH];

    logic                push, pop, grant_ok, multi_hot, zero_hot;
    logic [ID_WIDTH-1:0] grant_id;

    assign pop       = evt_valid_o & evt_ready_i;
    assign zero_hot  = (grant_i == '0);
    assign multi_hot = ((grant_i & (grant_i - EVNT_NUM'(1))) != '0);
    assign grant_ok  = any_grant_i & ~zero_hot;

    // Gated by rstn_i so the arbiter never sees an ack while the FIFO is held in reset.
    assign grant_ack_o = rstn_i & grant_ok & ((level_q < LW'(DEPTH)) | pop);
    assign push        = grant_ack_o;

    // Descending scan: the last hit written is the lowest set index.
    always_comb begin
        grant_id = '0;
        for (int i = EVNT_NUM - 1; i >= 0; i--) begin
            if (grant_i[i]) grant_id = ID_WIDTH'(i);
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Set has priority over clear so a fresh error is never lost.
    always_comb begin
        err_d = clr_err_i ? 2'b00 : err_q;
        if (any_grant_i & multi_hot) err_d[0] = 1'b1;
        if (any_grant_i & zero_hot)  err_d[1] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            err_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= grant_id;
    end

    assign evt_valid_o  = (level_q != '0);
    assign evt_data_o   = evt_valid_o ? mem_q[rptr_q] : '0;
    assign fifo_level_o = level_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_soc_event_fifo_sink.sv
// tb/tb_soc_event_fifo_sink.sv - randomized self-checking bench for soc_event_fifo_sink
module tb_soc_event_fifo_sink;

    localparam int EVNT_NUM = 256;
    localparam int DEPTH    = 8;

    logic                clk_i = 1'b0;
    logic                rstn_i;
    logic [EVNT_NUM-1:0] grant_i;
    logic                any_grant_i;
    logic                grant_ack_o;
    logic                evt_valid_o;
    logic [7:0]          evt_data_o;
    logic                evt_ready_i;
    logic [3:0]          fifo_level_o;
    logic [1:0]          err_o;
    logic                clr_err_i;

    soc_event_fifo_sink #(.EVNT_NUM(EVNT_NUM), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .grant_i      (grant_i),
        .any_grant_i  (any_grant_i),
        .grant_ack_o  (grant_ack_o),
        .evt_valid_o  (evt_valid_o),
        .evt_data_o   (evt_data_o),
        .evt_ready_i  (evt_ready_i),
        .fifo_level_o (fifo_level_o),
        .err_o        (err_o),
        .clr_err_i    (clr_err_i)
    );

    always #5 clk_i = ~clk_i;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        q[$];
    logic [1:0] err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [EVNT_NUM-1:0] g);
        for (int i = 0; i < EVNT_NUM; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(evt_valid_o), 32'(q.size() != 0));
        check({tag, ".level"}, 32'(fifo_level_o), 32'(q.size()));
        check({tag, ".data"},  32'(evt_data_o), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check({tag, ".err"},   32'(err_o), 32'(err_m));
    endtask

    // One clock: drive at negedge, check ack combinationally, update model at posedge, check state.
    task automatic cycle(input string tag, input logic [EVNT_NUM-1:0] g, input logic ag,
                         input logic rdy, input logic clr);
        bit pop, ok, ack;
        grant_i = g; any_grant_i = ag; evt_ready_i = rdy; clr_err_i = clr;
        #1;
        pop = (q.size() != 0) && rdy;
        ok  = ag && (g != '0);
        ack = ok && ((q.size() < DEPTH) || pop);
        check({tag, ".ack"}, 32'(grant_ack_o), 32'(ack));
        @(posedge clk_i);
        if (pop) void'(q.pop_front());
        if (ack) q.push_back(lowest(g));
        if (clr) err_m = 2'b00;
        if (ag && $countones(g) > 1) err_m[0] = 1'b1;
        if (ag && g == '0)           err_m[1] = 1'b1;
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    function automatic logic [EVNT_NUM-1:0] onehot(input int idx);
        logic [EVNT_NUM-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [EVNT_NUM-1:0] g;
        int sel;
        rstn_i = 1'b0; grant_i = '0; any_grant_i = 1'b0; evt_ready_i = 1'b0; clr_err_i = 1'b0;
        err_m = 2'b00;
        repeat (3) @(negedge clk_i);
        check("reset.ack", 32'(grant_ack_o), 32'd0);
        check_outputs("reset");
        rstn_i = 1'b1;

        // single grant, then pop
        cycle("single", onehot(5), 1'b1, 1'b0, 1'b0);
        cycle("single_pop", '0, 1'b0, 1'b1, 1'b0);

        // fill, stall on full, pop-while-full, drain
        for (int i = 0; i < DEPTH; i++) cycle("fill", onehot(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("full_hold", onehot(200), 1'b1, 1'b0, 1'b0);
        cycle("full_pop", onehot(200), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", '0, 1'b0, 1'b1, 1'b0);

        // wrap-around streaming
        for (int i = 0; i < 20; i++) cycle("stream", onehot(255 - i), 1'b1, 1'b1, 1'b0);
        cycle("stream_end", '0, 1'b0, 1'b1, 1'b0);

        // multi-hot, clear, set-beats-clear
        cycle("multi", onehot(3) | onehot(9), 1'b1, 1'b0, 1'b0);
        cycle("clr", '0, 1'b0, 1'b1, 1'b1);
        cycle("set_vs_clr", onehot(3) | onehot(9), 1'b1, 1'b0, 1'b1);
        cycle("clr2", '0, 1'b0, 1'b0, 1'b1);

        // zero-hot
        cycle("zero", '0, 1'b1, 1'b0, 1'b0);

        // bring to level 5, then asynchronous reset mid-cycle with a grant present
        while (q.size() > 5) cycle("trim", '0, 1'b0, 1'b1, 1'b0);
        while (q.size() < 5) cycle("load", onehot(q.size() + 40), 1'b1, 1'b0, 1'b0);
        grant_i = onehot(12); any_grant_i = 1'b1; evt_ready_i = 1'b0; clr_err_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        check("arst.valid", 32'(evt_valid_o), 32'd0);
        check("arst.level", 32'(fifo_level_o), 32'd0);
        check("arst.ack",   32'(grant_ack_o), 32'd0);
        check("arst.err",   32'(err_o), 32'd0);
        q.delete();
        err_m = 2'b00;
        @(negedge clk_i);
        rstn_i = 1'b1;
        cycle("post_rst", onehot(77), 1'b1, 1'b0, 1'b0);
        check("post_rst.first", 32'(evt_data_o), 32'd77);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            g = onehot(int'($urandom_range(0, EVNT_NUM - 1)));
            if (sel == 0) g = '0;
            else if (sel == 1) g = g | onehot(int'($urandom_range(0, EVNT_NUM - 1)));
            cycle("rand", g, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
